// File: rtl/strip_trigger_record_builder.sv
// Strip trigger record builder: windowed per-pad layer coincidence, BCID-tagged band
// records buffered in a FIFO and released to the serializer on a fixed load phase.
module strip_trigger_record_builder #(
    parameter int N_LAYER    = 4,
    parameter int N_PAD      = 128,
    parameter int BAND_W     = 8,
    parameter int BCID_W     = 12,
    parameter int WIN_W      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LOAD_DIV   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_LAYER*N_PAD-1:0]    layer_hit,
    input  logic                        hit_valid,
    input  logic [BCID_W-1:0]           bcid,
    input  logic [WIN_W-1:0]            match_window,
    input  logic [2:0]                  coinc_thr,
    input  logic [N_LAYER-1:0]          layer_enable,
    input  logic                        out_ready,
    output logic                        load,
    output logic [BCID_W-1:0]           trig_bcid,
    output logic [BAND_W-1:0]           trig_band_id,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [15:0]                 overflow_cnt,
    output logic                        busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int PH_W  = $clog2(LOAD_DIV);
    localparam int REC_W = BCID_W + BAND_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_EVAL    = 2'd2;
    localparam logic [1:0] S_PUSH    = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [N_LAYER*N_PAD-1:0]   acc_q, acc_d, hit_m;
    logic [BCID_W-1:0]          cap_bcid_q, cap_bcid_d;
    logic [WIN_W-1:0]           cnt_q, cnt_d;
    logic [BAND_W-1:0]          band_q, band_d, eval_band;
    logic                       eval_found, push, push_ok, pop;
    logic [2:0]                 thr_eff;

    logic [REC_W-1:0]           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]             count_q;
    logic [15:0]                ovf_q;
    logic [PH_W-1:0]            phase_q;
    logic                       load_q;
    logic [BCID_W-1:0]          trig_bcid_q;
    logic [BAND_W-1:0]          trig_band_q;

    function automatic logic [2:0] pad_count(input logic [N_LAYER*N_PAD-1:0] a, input int p);
        logic [2:0] c;
        c = '0;
        for (int l = 0; l < N_LAYER; l++) c = c + {2'b00, a[l*N_PAD + p]};
        return c;
    endfunction

    always_comb begin
        for (int l = 0; l < N_LAYER; l++)
            hit_m[l*N_PAD +: N_PAD] = layer_hit[l*N_PAD +: N_PAD] & {N_PAD{layer_enable[l]}};
    end

    // Descending scan so the lowest qualifying pad is the one left in eval_band.
    always_comb begin
        thr_eff    = (coinc_thr == 3'd0) ? 3'd1 : coinc_thr;
        eval_found = 1'b0;
        eval_band  = '0;
        for (int p = N_PAD - 1; p >= 0; p--) begin
            if (pad_count(acc_q, p) >= thr_eff) begin
                eval_found = 1'b1;
                eval_band  = BAND_W'(p);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cap_bcid_d = cap_bcid_q;
        cnt_d      = cnt_q;
        band_d     = band_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hit_valid && (|hit_m)) begin
                    state_d    = S_COLLECT;
                    acc_d      = hit_m;
                    cap_bcid_d = bcid;
                    cnt_d      = match_window;
                end
            end
            S_COLLECT: begin
                if (hit_valid) acc_d = acc_q | hit_m;
                if (cnt_q == '0) state_d = S_EVAL;
                else             cnt_d   = cnt_q - WIN_W'(1);
            end
            S_EVAL: begin
                band_d  = eval_band;
                state_d = eval_found ? S_PUSH : S_IDLE;
            end
            default: begin
                push    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign pop     = (phase_q == PH_W'(LOAD_DIV - 1)) && (count_q != '0) && out_ready;
    assign push_ok = push && ((count_q != (PTR_W+1)'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cap_bcid_q  <= '0;
            cnt_q       <= '0;
            band_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= '0;
            phase_q     <= '0;
            load_q      <= 1'b0;
            trig_bcid_q <= '0;
            trig_band_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cap_bcid_q <= cap_bcid_d;
            cnt_q      <= cnt_d;
            band_q     <= band_d;
            phase_q    <= (phase_q == PH_W'(LOAD_DIV - 1)) ? '0 : phase_q + PH_W'(1);
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};
            if (push && !push_ok && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
            load_q <= pop;
            if (pop) {trig_bcid_q, trig_band_q} <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem_q[wr_ptr_q] <= {cap_bcid_q, band_q};
    end

    assign load         = load_q;
    assign trig_bcid    = trig_bcid_q;
    assign trig_band_id = trig_band_q;
    assign fifo_count   = count_q;
    assign overflow_cnt = ovf_q;
    assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_strip_trigger_record_builder.sv
// Directed and randomized bench for strip_trigger_record_builder against a
// coincidence-rule reference model and an expected-record queue.
module tb_strip_trigger_record_builder;
    localparam int NL = 4;
    localparam int NP = 128;
    localparam int LD = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NL*NP-1:0]  layer_hit;
    logic              hit_valid;
    logic [11:0]       bcid;
    logic [7:0]        match_window;
    logic [2:0]        coinc_thr;
    logic [NL-1:0]     layer_enable;
    logic              out_ready;
    logic              load;
    logic [11:0]       trig_bcid;
    logic [7:0]        trig_band_id;
    logic [4:0]        fifo_count;
    logic [15:0]       overflow_cnt;
    logic              busy;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int last_load = -1;
    int nloads = 0;
    int push_cyc = 0;
    bit gap_check = 0;
    logic [19:0]      expq[$];
    logic [NL*NP-1:0] pat[8];
    logic             pv[8];

    strip_trigger_record_builder dut (
        .clk(clk), .reset(reset), .layer_hit(layer_hit), .hit_valid(hit_valid),
        .bcid(bcid), .match_window(match_window), .coinc_thr(coinc_thr),
        .layer_enable(layer_enable), .out_ready(out_ready), .load(load),
        .trig_bcid(trig_bcid), .trig_band_id(trig_band_id), .fifo_count(fifo_count),
        .overflow_cnt(overflow_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        logic r;
        r = reset;
        @(posedge clk);
        #1;
        if (r) cyc = 0;
        else   cyc++;
        if (load === 1'b1) begin
            if (expq.size() == 0) chk("load_unexpected", 32'(load), 32'd0);
            else begin
                chk("load_bcid", 32'(trig_bcid), 32'(expq[0][19:8]));
                chk("load_band", 32'(trig_band_id), 32'(expq[0][7:0]));
                void'(expq.pop_front());
            end
            chk("load_phase", cyc % LD, 0);
            if (gap_check && last_load >= 0) chk("load_gap", cyc - last_load, LD);
            last_load = cyc;
            nloads++;
        end
    endtask

    task automatic idle(input int n);
        hit_valid = 1'b0;
        layer_hit = '0;
        repeat (n) tick();
    endtask

    task automatic clear_pat();
        for (int k = 0; k < 8; k++) begin
            pat[k] = '0;
            pv[k]  = 1'b0;
        end
    endtask

    task automatic set_hit(input int k, input int l, input int p);
        pat[k][l*NP + p] = 1'b1;
        pv[k] = 1'b1;
    endtask

    // Drives one window: hits, quiet collect cycles, the eval cycle (optionally with
    // junk hits that must be ignored) and the push cycle.
    task automatic send(input logic [11:0] b0, input int n, input bit garbage, input int ready_at);
        int mw;
        mw = int'(match_window);
        for (int e = 0; e < mw + 4; e++) begin
            if (e == ready_at) out_ready = 1'b1;
            if (e < n) begin
                layer_hit = pat[e];
                hit_valid = pv[e];
                bcid      = b0 + 12'(e);
            end else if (e == mw + 2 && garbage) begin
                for (int i = 0; i < NL*NP/32; i++) layer_hit[i*32 +: 32] = $urandom;
                hit_valid = 1'b1;
                bcid      = 12'($urandom);
            end else begin
                hit_valid = 1'b0;
                layer_hit = '0;
            end
            tick();
            if (e == 0) chk("busy_collect", 32'(busy), 32'd1);
        end
        hit_valid = 1'b0;
        layer_hit = '0;
        push_cyc  = cyc;
    endtask

    task automatic quick(input logic [11:0] b0, input int pad, input bit accept);
        clear_pat();
        for (int l = 0; l < NL; l++) set_hit(0, l, pad);
        if (accept) expq.push_back({b0, 8'(pad)});
        send(b0, 1, 1'b0, -1);
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        hit_valid = 1'b0;
        layer_hit = '0;
        while (expq.size() != 0 && t < budget) begin
            tick();
            t++;
        end
        chk("drain_done", expq.size(), 0);
        idle(2);
        chk("fifo_empty", 32'(fifo_count), 32'd0);
    endtask

    function automatic void model(input int n, output bit found, output logic [7:0] band);
        int need;
        int layers;
        bit seen;
        need  = (coinc_thr == 3'd0) ? 1 : int'(coinc_thr);
        found = 1'b0;
        band  = '0;
        for (int p = 0; p < NP && !found; p++) begin
            layers = 0;
            for (int l = 0; l < NL; l++) begin
                seen = 1'b0;
                for (int k = 0; k < n; k++) seen = seen | (pv[k] & pat[k][l*NP + p]);
                if (layer_enable[l] && seen) layers++;
            end
            if (layers >= need) begin
                found = 1'b1;
                band  = 8'(p);
            end
        end
    endfunction

    initial begin
        int lb;
        int l0;
        reset = 1'b1; layer_hit = '0; hit_valid = 1'b0; bcid = '0;
        match_window = 8'd2; coinc_thr = 3'd3; layer_enable = 4'hF; out_ready = 1'b1;
        clear_pat();
        tick(); tick();
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_fifo", 32'(fifo_count), 32'd0);
        chk("rst_ovf", 32'(overflow_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bcid", 32'(trig_bcid), 32'd0);
        chk("rst_band", 32'(trig_band_id), 32'd0);
        reset = 1'b0;
        idle(3);

        // Two-cycle coincidence on pad 37, BCID from the first hit.
        clear_pat();
        set_hit(0, 0, 37); set_hit(0, 1, 37); set_hit(1, 2, 37); set_hit(1, 3, 37);
        expq.push_back({12'h123, 8'd37});
        lb = nloads;
        send(12'h123, 2, 1'b0, -1);
        wait_drain(40);
        chk("t1_loads", nloads - lb, 1);
        chk("t1_latency", last_load - push_cyc, LD - (push_cyc % LD));

        // Lowest qualifying pad wins; then a three-layer pad at threshold 4 is rejected.
        clear_pat();
        for (int l = 0; l < NL; l++) begin
            set_hit(0, l, 90);
            set_hit(1, l, 12);
        end
        expq.push_back({12'h200, 8'd12});
        send(12'h200, 2, 1'b0, -1);
        wait_drain(40);
        coinc_thr = 3'd4;
        clear_pat();
        set_hit(0, 0, 12); set_hit(0, 1, 12); set_hit(1, 2, 12);
        send(12'h210, 2, 1'b1, -1);
        idle(8);
        chk("t2_ovf", 32'(overflow_cnt), 32'd0);
        chk("t2_fifo", 32'(fifo_count), 32'd0);

        // Disabled layer cannot contribute; threshold 0 acts as 1.
        layer_enable = 4'b0111;
        clear_pat();
        for (int l = 0; l < NL; l++) set_hit(0, l, 5);
        send(12'h300, 1, 1'b0, -1);
        idle(8);
        chk("t3_nofifo", 32'(fifo_count), 32'd0);
        layer_enable = 4'hF;
        coinc_thr = 3'd0;
        clear_pat();
        set_hit(0, 2, 5);
        expq.push_back({12'h301, 8'd5});
        send(12'h301, 1, 1'b0, -1);
        wait_drain(40);

        // Eighteen records into a stalled serializer, then a paced drain.
        coinc_thr = 3'd1;
        out_ready = 1'b0;
        for (int w = 0; w < 18; w++) quick(12'h400 + 12'(w), int'($urandom_range(0, NP-1)), w < 16);
        chk("t4_fifo", 32'(fifo_count), 32'd16);
        chk("t4_ovf", 32'(overflow_cnt), 32'd2);
        gap_check = 1'b1;
        last_load = -1;
        lb = nloads;
        out_ready = 1'b1;
        wait_drain(200);
        chk("t4_loads", nloads - lb, 16);
        gap_check = 1'b0;

        // Full FIFO, push lands on the pop edge.
        out_ready = 1'b0;
        for (int w = 0; w < 16; w++) quick(12'h500 + 12'(w), int'($urandom_range(0, NP-1)), 1'b1);
        chk("t5_full", 32'(fifo_count), 32'd16);
        while (((cyc + int'(match_window) + 4) % LD) != 0) idle(1);
        clear_pat();
        set_hit(0, 0, 66);
        expq.push_back({12'h5AA, 8'd66});
        send(12'h5AA, 1, 1'b0, int'(match_window) + 3);
        chk("t5_fifo", 32'(fifo_count), 32'd16);
        chk("t5_ovf", 32'(overflow_cnt), 32'd2);
        wait_drain(200);

        // Reset in the middle of a window with records buffered.
        out_ready = 1'b0;
        for (int w = 0; w < 3; w++) quick(12'h600 + 12'(w), 20 + w, 1'b1);
        chk("t6_fifo3", 32'(fifo_count), 32'd3);
        clear_pat();
        set_hit(0, 1, 44);
        layer_hit = pat[0]; hit_valid = 1'b1; bcid = 12'h650;
        tick();
        idle(1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_fifo", 32'(fifo_count), 32'd0);
        chk("t6_load", 32'(load), 32'd0);
        chk("t6_ovf", 32'(overflow_cnt), 32'd0);
        expq.delete();
        clear_pat();
        set_hit(0, 3, 77);
        expq.push_back({12'h7A5, 8'd77});
        out_ready = 1'b1;
        send(12'h7A5, 1, 1'b0, -1);
        wait_drain(40);

        // Randomized windows against the coincidence model.
        for (int w = 0; w < 12; w++) begin
            int n;
            int base;
            int nb;
            bit f;
            logic [7:0] bd;
            logic [11:0] b0;
            match_window = 8'($urandom_range(0, 4));
            coinc_thr    = 3'($urandom_range(0, 4));
            layer_enable = 4'($urandom_range(1, 15));
            out_ready    = 1'($urandom_range(0, 1));
            n    = int'($urandom_range(1, int'(match_window) + 1));
            b0   = 12'($urandom);
            base = int'($urandom_range(0, NP - 8));
            clear_pat();
            for (int k = 0; k < n; k++) begin
                nb = int'($urandom_range(1, 5));
                pv[k] = (k == 0) || ($urandom_range(0, 3) != 0);
                for (int j = 0; j < nb; j++)
                    pat[k][int'($urandom_range(0, NL-1))*NP + base + int'($urandom_range(0, 7))] = 1'b1;
            end
            l0 = int'($urandom_range(0, NL-1));
            while (!layer_enable[l0]) l0 = int'($urandom_range(0, NL-1));
            pat[0][l0*NP + base + int'($urandom_range(0, 7))] = 1'b1;
            model(n, f, bd);
            if (f) expq.push_back({b0, bd});
            send(b0, n, 1'b1, -1);
            chk("rnd_idle", 32'(busy), 32'd0);
        end
        out_ready = 1'b1;
        wait_drain(200);
        chk("rnd_ovf", 32'(overflow_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
